// File: rtl/alu_nibble_sequencer_if.sv
// Request, slice and response signal bundle for the nibble-serial ALU sequencer.
// The sequencer sits on the slave modport; the requester/slice side uses master.
interface alu_nibble_sequencer_if #(
    parameter int unsigned NIBBLES = 2
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic [2:0]   req_op;

    logic [3:0]   slice_a;
    logic [3:0]   slice_b;
    logic         slice_cin;
    logic [2:0]   slice_s;
    logic [3:0]   slice_out;
    logic         slice_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_op,
        output slice_out, slice_cout,
        output rsp_ready,
        input  req_ready,
        input  slice_a, slice_b, slice_cin, slice_s,
        input  rsp_valid, rsp_result, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_op,
        input  slice_out, slice_cout,
        input  rsp_ready,
        output req_ready,
        output slice_a, slice_b, slice_cin, slice_s,
        output rsp_valid, rsp_result, rsp_cout
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives one multi-nibble operation through a 4-bit ALU slice, LSB nibble first,
// chaining the carry in a register and returning the assembled result.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_nibble_sequencer_if.slave bus,
    output logic                 busy
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

    state_e state_q, state_d;

    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [2:0]      op_q, op_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic       last;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (cnt_q == CntW'(k)) begin
                nib_a = a_q[4*k +: 4];
                nib_b = b_q[4*k +: 4];
            end
        end
    end

    assign last = (cnt_q == CntW'(NIBBLES - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req_valid)  state_d = StRun;
            StRun:   if (last)           state_d = StResp;
            StResp:  if (bus.rsp_ready)  state_d = StIdle;
            default:                     state_d = StIdle;
        endcase
    end

    // FSM outputs; slice ports held at zero outside RUN so the slice stays quiet
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.rsp_valid  = (state_q == StResp);
        busy           = (state_q == StRun) || (state_q == StResp);
        bus.rsp_result = res_q;
        bus.rsp_cout   = cout_q;
        bus.slice_a    = '0;
        bus.slice_b    = '0;
        bus.slice_cin  = 1'b0;
        bus.slice_s    = '0;
        if (state_q == StRun) begin
            bus.slice_a   = nib_a;
            bus.slice_b   = nib_b;
            bus.slice_cin = carry_q;
            bus.slice_s   = op_q;
        end
    end

    // Datapath next state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    carry_d = bus.req_cin;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                for (int unsigned k = 0; k < NIBBLES; k++) begin
                    if (cnt_q == CntW'(k)) res_d[4*k +: 4] = bus.slice_out;
                end
                carry_d = bus.slice_cout;
                if (last) begin
                    cout_d = bus.slice_cout;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer (NIBBLES=2) with an adder stub standing in
// for the ALU slice; expected values are hand-computed per vector.
module tb_alu_nibble_sequencer;
    localparam int unsigned NIBBLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    // Slice stub: plain 4-bit add with carry
    assign {bus.slice_cout, bus.slice_out} =
        5'(bus.slice_a) + 5'(bus.slice_b) + 5'(bus.slice_cin);

    alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request from IDLE and follow it to the response handshake
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [2:0] op, input logic [7:0] exp_r,
                          input logic exp_c, input logic exp_hi_cin, input int hold);
        int n;
        check({tag, ".req_ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_op    = op;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = ~a;
        bus.req_b     = ~b;
        bus.req_cin   = ~cin;
        bus.req_op    = ~op;
        check({tag, ".busy"}, busy, 1);
        check({tag, ".ready_run"}, bus.req_ready, 0);
        check({tag, ".s_lo"}, bus.slice_s, op);
        check({tag, ".a_lo"}, bus.slice_a, a[3:0]);
        check({tag, ".b_lo"}, bus.slice_b, b[3:0]);
        check({tag, ".cin_lo"}, bus.slice_cin, cin);
        check({tag, ".valid_run0"}, bus.rsp_valid, 0);
        @(negedge clk);
        check({tag, ".s_hi"}, bus.slice_s, op);
        check({tag, ".a_hi"}, bus.slice_a, a[7:4]);
        check({tag, ".cin_hi"}, bus.slice_cin, exp_hi_cin);
        check({tag, ".valid_run1"}, bus.rsp_valid, 0);
        @(negedge clk);
        check({tag, ".latency"}, bus.rsp_valid, 1);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".result"}, bus.rsp_result, exp_r);
        check({tag, ".cout"}, bus.rsp_cout, exp_c);
        check({tag, ".slice_idle"}, {bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_s}, 0);
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = ~bus.req_valid;
            bus.req_a     = 8'hA5 ^ 8'(i);
            @(negedge clk);
            check({tag, ".hold_valid"}, bus.rsp_valid, 1);
            check({tag, ".hold_result"}, bus.rsp_result, exp_r);
            check({tag, ".hold_cout"}, bus.rsp_cout, exp_c);
            check({tag, ".hold_ready"}, bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, ".valid_done"}, bus.rsp_valid, 0);
        check({tag, ".ready_done"}, bus.req_ready, 1);
        check({tag, ".busy_done"}, busy, 0);
    endtask

    logic [7:0] va [3] = '{8'h11, 8'h80, 8'h9A};
    logic [7:0] vb [3] = '{8'h22, 8'h80, 8'h66};
    logic       vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] er [3] = '{8'h33, 8'h01, 8'h00};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        int i_rsp;
        int n_acc;
        int last_acc;
        int guard;

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", bus.req_ready, 1);
        check("rst.rsp_valid", bus.rsp_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.result", bus.rsp_result, 0);
        check("rst.cout", bus.rsp_cout, 0);
        check("rst.slice", {bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_s}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // req_valid never seen high: nothing should start
        check("idle.busy", busy, 0);

        run_op("s1", 8'h3C, 8'h0F, 1'b0, 3'b101, 8'h4B, 1'b0, 1'b1, 0);
        run_op("s2", 8'hFF, 8'h01, 1'b0, 3'b010, 8'h00, 1'b1, 1'b1, 0);
        run_op("s3", 8'h0F, 8'h00, 1'b1, 3'b000, 8'h10, 1'b0, 1'b1, 0);
        run_op("s4", 8'h5A, 8'h27, 1'b0, 3'b111, 8'h81, 1'b0, 1'b1, 5);

        // Reset during the high-nibble pass abandons the operation
        bus.req_valid = 1'b1;
        bus.req_a     = 8'hEE;
        bus.req_b     = 8'h22;
        bus.req_cin   = 1'b0;
        bus.req_op    = 3'b011;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s5.rst_busy", busy, 0);
        check("s5.rst_ready", bus.req_ready, 1);
        check("s5.rst_result", bus.rsp_result, 0);
        check("s5.rst_slice", {bus.slice_a, bus.slice_b, bus.slice_cin, bus.slice_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("s5.no_stale", bus.rsp_valid, 0);
        end
        run_op("s5", 8'h12, 8'h34, 1'b0, 3'b001, 8'h46, 1'b0, 1'b0, 0);

        // Back-to-back: operands reloaded while in RESP, where req_* is ignored
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_a     = va[0];
        bus.req_b     = vb[0];
        bus.req_cin   = vc[0];
        bus.req_op    = 3'b100;
        i_rsp    = 0;
        n_acc    = 0;
        last_acc = 0;
        guard    = 0;
        while (i_rsp < 3 && guard < 40) begin
            if (bus.req_ready && bus.req_valid) begin
                if (n_acc > 0) check("s6.spacing", cyc - last_acc, 4);
                last_acc = cyc;
                n_acc++;
            end
            if (bus.rsp_valid) begin
                check("s6.result", bus.rsp_result, er[i_rsp]);
                check("s6.cout", bus.rsp_cout, ec[i_rsp]);
                i_rsp++;
                if (i_rsp < 3) begin
                    bus.req_a   = va[i_rsp];
                    bus.req_b   = vb[i_rsp];
                    bus.req_cin = vc[i_rsp];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
            guard++;
        end
        check("s6.responses", i_rsp, 3);
        check("s6.accepts", n_acc, 3);
        bus.rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
